prv_trap_sequencer: RTL and testbench
=====================================

PRV_TRAP_SEQUENCER -- requirements
Module: prv_trap_sequencer

Interface
REQ-001 SHALL have parameter VECTORED_EN, default 1, meaning 1 enables mtvec vectored mode for interrupts.
REQ-002 SHALL have parameter WORD_W, default 32, meaning data and address width.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset: port CLK in, port nRST in.
REQ-004 CLK  in  1  system clock, rising edge.
REQ-005 nRST  in  1  asynchronous active-low reset.
REQ-006 exc_vec  in  9  exception flags {fault_l, fault_s, mal_l, mal_s, env, breakpoint, mal_insn, illegal_insn, fault_insn}, LSB first.
REQ-007 int_pend  in  3  pending interrupts {ext, timer, soft}, already masked by mie.
REQ-008 mie_global  in  1  mstatus.MIE.
REQ-009 ret  in  1  mret retiring.
REQ-010 wfi  in  1  wfi retiring.
REQ-011 pipe_clear  in  1  pipeline drained.
REQ-012 epc, badaddr, mtvec, mepc  in  WORD_W each  faulting PC, faulting address, CSR values.
REQ-013 insert_pc  out  1  redirect strobe.
REQ-014 priv_pc  out  WORD_W  redirect target.
REQ-015 intr  out  1  redirect caused by an interrupt.
REQ-016 trap_we  out  1  one-cycle write strobe for mcause, mepc, mtval, and the mstatus push.
REQ-017 mret_we  out  1  one-cycle mstatus pop strobe.
REQ-018 mcause_wdata, mepc_wdata, mtval_wdata  out  WORD_W each  CSR write data.
REQ-019 wfi_stall  out  1  hold fetch.
REQ-020 busy  out  1  sequencer not IDLE.

Function
REQ-021 FSM states SHALL be IDLE, DRAIN, COMMIT, REDIRECT, SLEEP; all outputs SHALL be registered.
REQ-022 In IDLE, the FSM SHALL service the first applicable event in this order, latching cause/epc/badaddr and going to DRAIN:
- any exc_vec bit;
- (int_pend!=0 && mie_global);
- ret.
Otherwise, if wfi, it SHALL go to SLEEP.
REQ-023 Exception priority SHALL be, highest first:
- fault_insn(1), illegal_insn(2), mal_insn(0), breakpoint(3), env(11), mal_s(6), mal_l(4), fault_s(7), fault_l(5).
Interrupt priority SHALL be ext(11) > soft(3) > timer(7).
REQ-024 A simultaneous exception and interrupt SHALL take the exception; the interrupt stays pending.
REQ-025 DRAIN SHALL hold until pipe_clear=1, then go to COMMIT.
REQ-026 COMMIT SHALL assert trap_we (or mret_we for ret) for exactly one cycle, then go to REDIRECT.
- mcause_wdata = {intr, cause zero-extended}.
- mepc_wdata = latched epc.
- mtval_wdata = latched badaddr for codes 0,1,4,5,6,7, else 0.
REQ-027 Trap target SHALL be {mtvec[31:2],2'b00}, plus 4*cause when VECTORED_EN && mtvec[1:0]==1 && interrupt; addition SHALL wrap modulo 2^WORD_W. ret target SHALL be mepc.
REQ-028 REDIRECT SHALL assert insert_pc for exactly one cycle with priv_pc valid, and intr=1 if interrupt, then return to IDLE.
REQ-029 Minimum latency: event in cycle N with pipe_clear=1 SHALL give insert_pc in cycle N+3.
REQ-030 Events arriving while busy=1 SHALL be ignored; the pipeline holds them.
REQ-031 SLEEP SHALL assert wfi_stall and exit to IDLE on any int_pend bit regardless of mie_global; with mie_global=0, execution resumes with no trap.
REQ-032 busy SHALL be 1 in every state except IDLE.

Reset
REQ-033 On nRST=0 the state SHALL go to IDLE immediately, mid-operation included, and all outputs and latched registers SHALL be 0; an in-flight trap is discarded.

Structure
REQ-034 The trap_state_t enum and the exception/interrupt cause codes SHALL live in machine_mode_types_1_12_pkg.
REQ-035 The priority selection SHALL be a combinational sub-module, prv_trap_priority_enc, that outputs a valid flag and the cause.

Verification
REQ-036 illegal_insn=1, epc=0x80, pipe_clear=1, mtvec=0x100 -> insert_pc at N+3, priv_pc=0x100, mcause=2, mtval=0.
REQ-037 fault_l and mal_insn together, badaddr=0x44 -> mcause=0 (mal_insn wins), mtval=0x44.
REQ-038 timer+ext pending, mie_global=1, mtvec=0x201 -> mcause=0x8000000B, priv_pc=0x22C, intr=1.
REQ-039 ret, pipe_clear held 0 for 5 cycles, mepc=0x400 -> stays in DRAIN, then mret_we, then insert_pc with priv_pc=0x400.
REQ-040 wfi, mie_global=0, soft pending after 10 cycles -> wfi_stall for 10 cycles, no trap_we, back to IDLE.
REQ-041 nRST low during DRAIN -> no trap_we, no insert_pc, busy=0.

Source files
------------

// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared machine-mode trap types: sequencer states, cause codes and exception bit positions.
package machine_mode_types_1_12_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_REDIRECT,
    ST_SLEEP
  } trap_state_t;

  localparam int CAUSE_W = 4;

  // Exception cause codes
  localparam logic [CAUSE_W-1:0] EXC_MAL_INSN     = 4'd0;
  localparam logic [CAUSE_W-1:0] EXC_FAULT_INSN   = 4'd1;
  localparam logic [CAUSE_W-1:0] EXC_ILLEGAL_INSN = 4'd2;
  localparam logic [CAUSE_W-1:0] EXC_BREAKPOINT   = 4'd3;
  localparam logic [CAUSE_W-1:0] EXC_MAL_L        = 4'd4;
  localparam logic [CAUSE_W-1:0] EXC_FAULT_L      = 4'd5;
  localparam logic [CAUSE_W-1:0] EXC_MAL_S        = 4'd6;
  localparam logic [CAUSE_W-1:0] EXC_FAULT_S      = 4'd7;
  localparam logic [CAUSE_W-1:0] EXC_ENV          = 4'd11;

  // Interrupt cause codes
  localparam logic [CAUSE_W-1:0] INT_SOFT  = 4'd3;
  localparam logic [CAUSE_W-1:0] INT_TIMER = 4'd7;
  localparam logic [CAUSE_W-1:0] INT_EXT   = 4'd11;

  // Bit positions inside exc_vec (bit 0 first)
  localparam int EB_FAULT_L      = 0;
  localparam int EB_FAULT_S      = 1;
  localparam int EB_MAL_L        = 2;
  localparam int EB_MAL_S        = 3;
  localparam int EB_ENV          = 4;
  localparam int EB_BREAKPOINT   = 5;
  localparam int EB_MAL_INSN     = 6;
  localparam int EB_ILLEGAL_INSN = 7;
  localparam int EB_FAULT_INSN   = 8;

  // Bit positions inside int_pend (bit 0 first)
  localparam int IB_EXT   = 0;
  localparam int IB_TIMER = 1;
  localparam int IB_SOFT  = 2;

  // Exceptions that report the faulting address through mtval
  function automatic logic cause_has_tval(input logic [CAUSE_W-1:0] cause);
    case (cause)
      EXC_MAL_INSN, EXC_FAULT_INSN, EXC_MAL_L,
      EXC_FAULT_L, EXC_MAL_S, EXC_FAULT_S: cause_has_tval = 1'b1;
      default:                             cause_has_tval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/prv_trap_priority_enc.sv
// Combinational trap arbiter: picks the highest-priority exception, else an enabled interrupt.
module prv_trap_priority_enc
  import machine_mode_types_1_12_pkg::*;
(
  input  logic [8:0]         exc_vec,
  input  logic [2:0]         int_pend,
  input  logic               mie_global,
  output logic               valid,
  output logic               is_int,
  output logic [CAUSE_W-1:0] cause
);

  // Exceptions always beat interrupts; the interrupt simply stays pending
  always_comb begin
    valid  = 1'b1;
    is_int = 1'b0;
    cause  = '0;
    if      (exc_vec[EB_FAULT_INSN])   cause = EXC_FAULT_INSN;
    else if (exc_vec[EB_ILLEGAL_INSN]) cause = EXC_ILLEGAL_INSN;
    else if (exc_vec[EB_MAL_INSN])     cause = EXC_MAL_INSN;
    else if (exc_vec[EB_BREAKPOINT])   cause = EXC_BREAKPOINT;
    else if (exc_vec[EB_ENV])          cause = EXC_ENV;
    else if (exc_vec[EB_MAL_S])        cause = EXC_MAL_S;
    else if (exc_vec[EB_MAL_L])        cause = EXC_MAL_L;
    else if (exc_vec[EB_FAULT_S])      cause = EXC_FAULT_S;
    else if (exc_vec[EB_FAULT_L])      cause = EXC_FAULT_L;
    else if ((int_pend != 3'b000) && mie_global) begin
      is_int = 1'b1;
      if      (int_pend[IB_EXT])  cause = INT_EXT;
      else if (int_pend[IB_SOFT]) cause = INT_SOFT;
      else                        cause = INT_TIMER;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/prv_trap_sequencer.sv
// Machine-mode trap/mret/wfi sequencer: drain, commit CSRs, then redirect fetch.
module prv_trap_sequencer
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int VECTORED_EN = 1,
  parameter int WORD_W      = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [8:0]        exc_vec,
  input  logic [2:0]        int_pend,
  input  logic              mie_global,
  input  logic              ret,
  input  logic              wfi,
  input  logic              pipe_clear,
  input  logic [WORD_W-1:0] epc,
  input  logic [WORD_W-1:0] badaddr,
  input  logic [WORD_W-1:0] mtvec,
  input  logic [WORD_W-1:0] mepc,
  output logic              insert_pc,
  output logic [WORD_W-1:0] priv_pc,
  output logic              intr,
  output logic              trap_we,
  output logic              mret_we,
  output logic [WORD_W-1:0] mcause_wdata,
  output logic [WORD_W-1:0] mepc_wdata,
  output logic [WORD_W-1:0] mtval_wdata,
  output logic              wfi_stall,
  output logic              busy
);

  trap_state_t        state_q, next_state;
  logic [CAUSE_W-1:0] cause_q;
  logic               intr_q, ret_q;
  logic [WORD_W-1:0]  epc_q, badaddr_q;

  logic               enc_valid, enc_is_int;
  logic [CAUSE_W-1:0] enc_cause;
  logic               latch_en;

  logic               insert_pc_d, intr_d, trap_we_d, mret_we_d, wfi_stall_d, busy_d;
  logic [WORD_W-1:0]  priv_pc_d, mcause_d, mepc_d, mtval_d, vec_off, trap_base;

  prv_trap_priority_enc u_prio (
    .exc_vec    (exc_vec),
    .int_pend   (int_pend),
    .mie_global (mie_global),
    .valid      (enc_valid),
    .is_int     (enc_is_int),
    .cause      (enc_cause)
  );

  // Next state; new events are only looked at while idle
  always_comb begin
    next_state = state_q;
    latch_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid || ret) begin
          next_state = ST_DRAIN;
          latch_en   = 1'b1;
        end else if (wfi) begin
          next_state = ST_SLEEP;
        end
      end
      ST_DRAIN:    if (pipe_clear) next_state = ST_COMMIT;
      ST_COMMIT:   next_state = ST_REDIRECT;
      ST_REDIRECT: next_state = ST_IDLE;
      ST_SLEEP:    if (int_pend != 3'b000) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Output values decoded from the upcoming state so the registered outputs line up with it
  always_comb begin
    trap_base = {mtvec[WORD_W-1:2], 2'b00};
    vec_off   = '0;
    vec_off[CAUSE_W+1:2] = cause_q;

    trap_we_d   = (next_state == ST_COMMIT) && (state_q == ST_DRAIN) && !ret_q;
    mret_we_d   = (next_state == ST_COMMIT) && (state_q == ST_DRAIN) && ret_q;
    insert_pc_d = (next_state == ST_REDIRECT);
    intr_d      = insert_pc_d && intr_q;
    wfi_stall_d = (next_state == ST_SLEEP);
    busy_d      = (next_state != ST_IDLE);

    mcause_d = '0;
    mepc_d   = '0;
    mtval_d  = '0;
    if (trap_we_d) begin
      mcause_d[CAUSE_W-1:0] = cause_q;
      mcause_d[WORD_W-1]    = intr_q;
      mepc_d                = epc_q;
      if (!intr_q && cause_has_tval(cause_q)) mtval_d = badaddr_q;
    end

    priv_pc_d = '0;
    if (insert_pc_d) begin
      if (ret_q)
        priv_pc_d = mepc;
      else if ((VECTORED_EN != 0) && (mtvec[1:0] == 2'b01) && intr_q)
        priv_pc_d = trap_base + vec_off;
      else
        priv_pc_d = trap_base;
    end
  end

  // State register and event capture
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      cause_q   <= '0;
      intr_q    <= 1'b0;
      ret_q     <= 1'b0;
      epc_q     <= '0;
      badaddr_q <= '0;
    end else begin
      state_q <= next_state;
      if (latch_en) begin
        cause_q   <= enc_valid ? enc_cause : '0;
        intr_q    <= enc_valid && enc_is_int;
        ret_q     <= !enc_valid;
        epc_q     <= epc;
        badaddr_q <= badaddr;
      end
    end
  end

  // Registered outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      insert_pc    <= 1'b0;
      priv_pc      <= '0;
      intr         <= 1'b0;
      trap_we      <= 1'b0;
      mret_we      <= 1'b0;
      mcause_wdata <= '0;
      mepc_wdata   <= '0;
      mtval_wdata  <= '0;
      wfi_stall    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      insert_pc    <= insert_pc_d;
      priv_pc      <= priv_pc_d;
      intr         <= intr_d;
      trap_we      <= trap_we_d;
      mret_we      <= mret_we_d;
      mcause_wdata <= mcause_d;
      mepc_wdata   <= mepc_d;
      mtval_wdata  <= mtval_d;
      wfi_stall    <= wfi_stall_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Self-checking bench for prv_trap_sequencer: directed cases plus randomized transactions vs a behavioural model.
module tb_prv_trap_sequencer;

  localparam int W   = 32;
  localparam int VEC = 1;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic [8:0]   exc_vec = '0;
  logic [2:0]   int_pend = '0;
  logic         mie_global = 1'b0, ret = 1'b0, wfi = 1'b0, pipe_clear = 1'b0;
  logic [W-1:0] epc = '0, badaddr = '0, mtvec = '0, mepc = '0;
  logic         insert_pc, intr, trap_we, mret_we, wfi_stall, busy;
  logic [W-1:0] priv_pc, mcause_wdata, mepc_wdata, mtval_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  prv_trap_sequencer #(.VECTORED_EN(VEC), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .exc_vec(exc_vec), .int_pend(int_pend),
    .mie_global(mie_global), .ret(ret), .wfi(wfi), .pipe_clear(pipe_clear),
    .epc(epc), .badaddr(badaddr), .mtvec(mtvec), .mepc(mepc),
    .insert_pc(insert_pc), .priv_pc(priv_pc), .intr(intr), .trap_we(trap_we),
    .mret_we(mret_we), .mcause_wdata(mcause_wdata), .mepc_wdata(mepc_wdata),
    .mtval_wdata(mtval_wdata), .wfi_stall(wfi_stall), .busy(busy)
  );

  task automatic check_output(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model: kind 0 = nothing, 1 = trap, 2 = mret
  function automatic void model(input logic [8:0] ev, input logic [2:0] ip, input bit mie,
                                input bit rt, input logic [W-1:0] mtv, input logic [W-1:0] mep,
                                input logic [W-1:0] bad, output int kind, output bit is_int,
                                output logic [W-1:0] mc, output logic [W-1:0] mt,
                                output logic [W-1:0] tgt);
    int exc_code [9];
    int code;
    exc_code = '{5, 7, 4, 6, 11, 3, 0, 2, 1};
    kind = 0; is_int = 0; code = 0;
    for (int i = 8; i >= 0; i--)
      if (ev[i] && kind == 0) begin kind = 1; code = exc_code[i]; end
    if (kind == 0 && ip != 0 && mie) begin
      kind = 1; is_int = 1;
      code = ip[0] ? 11 : (ip[2] ? 3 : 7);
    end
    if (kind == 0 && rt) kind = 2;
    mc = {is_int, 31'(code)};
    mt = (!is_int && (code inside {0, 1, 4, 5, 6, 7})) ? bad : '0;
    if (kind == 2) tgt = mep;
    else tgt = (mtv & ~32'h3) + ((VEC != 0 && mtv[1:0] == 2'b01 && is_int) ? 32'(code * 4) : 32'h0);
  endfunction

  task automatic clear_events();
    exc_vec = '0; int_pend = '0; ret = 1'b0; wfi = 1'b0;
  endtask

  // One transaction: event in cycle 0, pipe_clear rises in cycle d, optional noise while busy
  task automatic apply_stimulus(input logic [8:0] ev, input logic [2:0] ip, input bit mie,
                                input bit rt, input logic [W-1:0] e_pc, input logic [W-1:0] bad,
                                input logic [W-1:0] mtv, input logic [W-1:0] mep,
                                input int d, input bit noise, input string name);
    int kind, commit_c, ins_c, n_commit, n_ins, exp_commit;
    bit is_int, done;
    logic [W-1:0] mc, mt, tgt;
    @(negedge CLK);
    model(ev, ip, mie, rt, mtv, mep, bad, kind, is_int, mc, mt, tgt);
    exc_vec = ev; int_pend = ip; mie_global = mie; ret = rt; wfi = 1'b0;
    epc = e_pc; badaddr = bad; mtvec = mtv; mepc = mep;
    pipe_clear = (d == 0);
    if (kind == 0) begin
      n_commit = 0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge CLK);
        if (busy || trap_we || mret_we || insert_pc) n_commit++;
        clear_events();
      end
      check_output({name, "_no_event"}, 32'(n_commit), 32'd0);
      return;
    end
    commit_c = -1; ins_c = -1; n_commit = 0; n_ins = 0; done = 0;
    exp_commit = ((d > 1) ? d : 1) + 1;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge CLK);
      if (trap_we || mret_we) begin
        n_commit++;
        if (commit_c < 0) commit_c = c;
        check_output({name, "_trap_we"}, {31'd0, trap_we}, {31'd0, kind == 1});
        check_output({name, "_mret_we"}, {31'd0, mret_we}, {31'd0, kind == 2});
        if (kind == 1) begin
          check_output({name, "_mcause"}, mcause_wdata, mc);
          check_output({name, "_mepc"}, mepc_wdata, e_pc);
          check_output({name, "_mtval"}, mtval_wdata, mt);
        end
      end
      if (insert_pc) begin
        n_ins++;
        if (ins_c < 0) ins_c = c;
        check_output({name, "_priv_pc"}, priv_pc, tgt);
        check_output({name, "_intr"}, {31'd0, intr}, {31'd0, is_int});
      end
      if (busy) begin
        if (noise) begin
          exc_vec = 9'($urandom); int_pend = 3'($urandom); ret = 1'($urandom);
          wfi = 1'($urandom); epc = $urandom; badaddr = $urandom;
        end else clear_events();
      end else begin
        clear_events();
        done = 1;
      end
      pipe_clear = (c >= d);
    end
    check_output({name, "_commit_cycle"}, 32'(commit_c), 32'(exp_commit));
    check_output({name, "_insert_cycle"}, 32'(ins_c), 32'(exp_commit + 1));
    check_output({name, "_commit_count"}, 32'(n_commit), 32'd1);
    check_output({name, "_insert_count"}, 32'(n_ins), 32'd1);
    check_output({name, "_back_idle"}, {31'd0, done}, 32'd1);
  endtask

  // WFI with interrupts globally disabled: stall until soft interrupt, then resume with no trap
  task automatic wfi_test();
    int stall_cnt, bad_cnt;
    stall_cnt = 0; bad_cnt = 0;
    @(negedge CLK);
    clear_events(); mie_global = 1'b0; pipe_clear = 1'b1; wfi = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      wfi = 1'b0;
      if (wfi_stall) stall_cnt++;
      if (trap_we || insert_pc) bad_cnt++;
      if (c == 10) int_pend = 3'b100;
    end
    @(negedge CLK);
    check_output("wfi_exit_stall", {31'd0, wfi_stall}, 32'd0);
    check_output("wfi_exit_busy", {31'd0, busy}, 32'd0);
    int_pend = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (trap_we || mret_we || insert_pc || busy) bad_cnt++;
    end
    check_output("wfi_stall_cycles", 32'(stall_cnt), 32'd10);
    check_output("wfi_no_trap", 32'(bad_cnt), 32'd0);
  endtask

  // Asynchronous reset while draining discards the in-flight trap
  task automatic reset_test();
    int bad_cnt;
    bad_cnt = 0;
    @(negedge CLK);
    clear_events(); pipe_clear = 1'b0; mepc = 32'h400; ret = 1'b1;
    @(negedge CLK);
    ret = 1'b0;
    check_output("rst_busy_in_drain", {31'd0, busy}, 32'd1);
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_trap_we", {31'd0, trap_we}, 32'd0);
    check_output("rst_insert_pc", {31'd0, insert_pc}, 32'd0);
    pipe_clear = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (trap_we || mret_we || insert_pc || busy) bad_cnt++;
    end
    check_output("rst_discarded", 32'(bad_cnt), 32'd0);
  endtask

  initial begin
    logic [W-1:0] rnd_a, rnd_b;
    #23;
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_insert_pc", {31'd0, insert_pc}, 32'd0);
    check_output("reset_trap_we", {31'd0, trap_we}, 32'd0);
    check_output("reset_priv_pc", priv_pc, 32'd0);
    check_output("reset_mcause", mcause_wdata, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    apply_stimulus(9'h080, 3'b000, 1'b0, 1'b0, 32'h80, 32'h0, 32'h100, 32'h0, 0, 1'b0, "illegal");
    apply_stimulus(9'h041, 3'b000, 1'b0, 1'b0, 32'h90, 32'h44, 32'h100, 32'h0, 0, 1'b0, "malinsn_vs_faultl");
    apply_stimulus(9'h000, 3'b011, 1'b1, 1'b0, 32'hA0, 32'h0, 32'h201, 32'h0, 0, 1'b0, "ext_timer_vec");
    apply_stimulus(9'h000, 3'b000, 1'b0, 1'b1, 32'h0, 32'h0, 32'h100, 32'h400, 5, 1'b0, "mret_drain");
    apply_stimulus(9'h000, 3'b101, 1'b1, 1'b0, 32'hB0, 32'h0, 32'hFFFFFFF1, 32'h0, 1, 1'b0, "vec_wrap");
    apply_stimulus(9'h001, 3'b001, 1'b1, 1'b1, 32'hC0, 32'h55, 32'h201, 32'h0, 2, 1'b0, "exc_beats_int");
    apply_stimulus(9'h000, 3'b010, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100, 32'h0, 0, 1'b0, "masked_int");
    wfi_test();
    reset_test();

    for (int t = 0; t < 150; t++) begin
      rnd_a = $urandom;
      rnd_b = $urandom;
      apply_stimulus(($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'h000,
                     3'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                     {rnd_a[31:2], ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00},
                     rnd_b, $urandom_range(0, 4), 1'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
